commit_recovery_ctrl: RTL and testbench
=======================================

// Module: commit_recovery_ctrl
// PURPOSE
//  Retirement sequencer between the 3-wide ROB head and the architectural RAT copy.
//  Each cycle it selects the in-order prefix of ready head entries to commit.
//  It drives the per-slot commit strobes, including the exception flag, into the architectural RAT.
//  When an exception entry retires, it runs a precise-exception recovery: pipeline flush,
//  then an 8-cycle walk copying every architectural-RAT mapping back into the speculative RAT.
// PARAMETERS
//  NUM_AREG  8   architectural registers (walk length); power of two
//  AREG_W    3   log2(NUM_AREG)
//  PREG_W    5   physical register tag width
// PORTS
//  clk           in   1          clock
//  rst           in   1          synchronous, active-high reset
//  head_valid    in   3          ROB head slots x,y,z (bit0=x, oldest) hold an instruction
//  head_done     in   3          slot finished execution
//  head_exp      in   3          slot raised an exception
//  head_regwr    in   3          slot writes a register
//  head_rw       in   3*AREG_W   arch dest per slot ([2:0]=x)
//  head_pw       in   3*PREG_W   phys dest per slot
//  rob_pop       out  2          entries retired this cycle (0..3), combinational
//  RegWr_x/y/z   out  1 each     registered commit write strobes to arch RAT
//  exp_x/y/z     out  1 each     registered commit exception flags
//  Rw_commit_x/y/z out AREG_W    registered arch dest
//  Pw_commit_x/y/z out PREG_W    registered phys dest
//  flush         out  1          one-cycle pipeline/ROB flush pulse
//  arat_rd_idx   out  AREG_W     arch RAT read index (walk counter)
//  arat_rd_pw    in   PREG_W     arch RAT read data, combinational from arat_rd_idx
//  rat_wr_en     out  1          speculative RAT restore write enable
//  rat_wr_idx    out  AREG_W     restore index (= arat_rd_idx)
//  rat_wr_pw     out  PREG_W     restore data (= arat_rd_pw)
//  busy          out  1          recovery in progress; front end must stall dispatch
//  perf_commit   out  32         retired-instruction count (see CONFIGURATION)
//  perf_exc      out  16         recovery count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: FSM=IDLE; walk counter=0; rob_pop, every commit output, flush, rat_wr_en, busy=0; perf=0.
//  FSM states: IDLE -> FLUSH -> RESTORE -> IDLE.
//  IDLE, commit selection (combinational):
//   - ready_i = head_valid[i] & head_done[i].
//   - Slot i commits iff ready_0..ready_i all hold and no older slot has head_exp.
//   - So commit stops after, and includes, the first exception slot.
//   - rob_pop = number of committing slots. A non-ready x gives rob_pop=0.
//  Commit outputs, registered; valid cycle T+1 for decision cycle T:
//   - RegWr_s = commit_s & head_regwr_s; exp_s = commit_s & head_exp_s; Rw/Pw copied.
//   - Non-committed slots drive all-zero. Outputs are 0 in any cycle with no commit.
//  Exception at T (a committing slot has head_exp):
//   - State=FLUSH at T+1 with flush=1 and busy=1. The arch RAT absorbs the T+1 commit at that edge.
//   - RESTORE for NUM_AREG cycles, T+2..T+9: rat_wr_en=1, arat_rd_idx=rat_wr_idx=counter (0..7).
//   - Counter increments each RESTORE cycle and wraps 7->0 on exit. Then IDLE at T+10.
//   - busy=1 from FLUSH through the last RESTORE cycle. flush is high only in the FLUSH cycle.
//  Inputs are ignored outside IDLE: rob_pop=0 and no commit strobes.
//  Two exceptions in one head window: only the oldest commits; younger slots are never committed.
//  Same Rw in several commit slots is passed unchanged; the arch RAT resolves youngest-wins.
//  Reset asserted mid-FLUSH/RESTORE: next edge returns to IDLE with all outputs 0 and no partial completion.
//  rat_wr_pw is combinational pass-through of arat_rd_pw. No arithmetic beyond the AREG_W counter.
// CONFIGURATION
//  COMMIT_PERF_CNT_EN defined:
//   - perf_commit += committed-slot count each IDLE cycle; 32-bit, wraps at 2^32.
//   - perf_exc += 1 on each FLUSH entry; 16-bit, wraps.
//  Not defined: counter logic is omitted; perf_commit and perf_exc are tied to 0. Ports always present.
// TESTING
//  1 Reset: rst=1 for 2 cycles with random heads -> all outputs 0, busy=0, rob_pop=0.
//  2 All 3 ready, no exp, rw=1/2/3, pw=9/10/11:
//    -> rob_pop=3 same cycle; next cycle RegWr_x/y/z=1, Pw=9/10/11.
//  3 x ready, y not done, z ready -> rob_pop=1; only RegWr_x strobes next cycle; z waits.
//  4 y has exp, all ready:
//    -> rob_pop=2; next cycle exp_y=1 and RegWr_z=0, flush=1 for one cycle.
//    -> then 8 cycles of rat_wr_en with idx 0..7 and rat_wr_pw equal to the ARAT model contents.
//    -> busy low at T+10 and commits resume.
//  5 rst pulsed during RESTORE idx=4 -> IDLE next cycle, rat_wr_en=0, new commits accepted.
//  6 COMMIT_PERF_CNT_EN: commits 3+2+1 then one exception -> perf_commit=6 before exc commit, perf_exc=1;
//    without the macro both read 0.

Source files
------------

// File: rtl/commit_recovery_ctrl_if.sv
// ROB head window bus between the reorder buffer and the retirement sequencer.
// The ROB side (master) presents up to three head entries, with bit 0 as the oldest.
// The sequencer side (slave) returns how many of those entries retired this cycle.
interface commit_recovery_ctrl_if #(
  parameter int unsigned AREG_W = 3,
  parameter int unsigned PREG_W = 5
);
  logic [2:0]          head_valid;
  logic [2:0]          head_done;
  logic [2:0]          head_exp;
  logic [2:0]          head_regwr;
  logic [3*AREG_W-1:0] head_rw;
  logic [3*PREG_W-1:0] head_pw;
  logic [1:0]          rob_pop;

  modport master (
    output head_valid, head_done, head_exp, head_regwr, head_rw, head_pw,
    input  rob_pop
  );

  modport slave (
    input  head_valid, head_done, head_exp, head_regwr, head_rw, head_pw,
    output rob_pop
  );
endinterface

// File: rtl/commit_recovery_ctrl.sv
// Retirement sequencer between the 3-wide ROB head and the architectural RAT copy.
// Commits the in-order ready prefix of the head window, stopping after the first exception.
// On an exception it pulses flush, then walks all arch registers to restore the
// speculative RAT from the architectural RAT.
// Optional feature macro: COMMIT_PERF_CNT_EN enables the retire/recovery counters;
// when it is undefined, perf_commit and perf_exc are tied to zero.
module commit_recovery_ctrl #(
  parameter int unsigned NUM_AREG = 8,
  parameter int unsigned AREG_W   = 3,
  parameter int unsigned PREG_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  commit_recovery_ctrl_if.slave rob,
  output logic                RegWr_x,
  output logic                RegWr_y,
  output logic                RegWr_z,
  output logic                exp_x,
  output logic                exp_y,
  output logic                exp_z,
  output logic [AREG_W-1:0]   Rw_commit_x,
  output logic [AREG_W-1:0]   Rw_commit_y,
  output logic [AREG_W-1:0]   Rw_commit_z,
  output logic [PREG_W-1:0]   Pw_commit_x,
  output logic [PREG_W-1:0]   Pw_commit_y,
  output logic [PREG_W-1:0]   Pw_commit_z,
  output logic                flush,
  output logic [AREG_W-1:0]   arat_rd_idx,
  input  logic [PREG_W-1:0]   arat_rd_pw,
  output logic                rat_wr_en,
  output logic [AREG_W-1:0]   rat_wr_idx,
  output logic [PREG_W-1:0]   rat_wr_pw,
  output logic                busy,
  output logic [31:0]         perf_commit,
  output logic [15:0]         perf_exc
);

  typedef enum logic [1:0] {StIdle, StFlush, StRestore} state_e;

  state_e              state_q;
  logic [AREG_W-1:0]   cnt_q;
  logic                flush_q;
  logic                busy_q;
  logic                rat_wr_en_q;
  logic [2:0]          regwr_q;
  logic [2:0]          exp_q;
  logic [3*AREG_W-1:0] rw_q;
  logic [3*PREG_W-1:0] pw_q;

  logic [2:0] ready;
  logic [2:0] commit;
  logic [1:0] pop;
  logic       exc_commit;

  // Commit selection: in-order ready prefix, cut after the oldest exception; only in IDLE.
  always_comb begin
    ready      = rob.head_valid & rob.head_done;
    commit     = 3'b000;
    commit[0]  = ready[0] & (state_q == StIdle) & ~rst;
    commit[1]  = commit[0] & ~rob.head_exp[0] & ready[1];
    commit[2]  = commit[1] & ~rob.head_exp[1] & ready[2];
    // commit is a thermometer code, so the count needs no adder
    pop[1]     = commit[1];
    pop[0]     = (commit[0] & ~commit[1]) | commit[2];
    exc_commit = |(commit & rob.head_exp);
  end

  assign rob.rob_pop = pop;

  // Recovery FSM plus registered commit strobes and walk counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      flush_q     <= 1'b0;
      busy_q      <= 1'b0;
      rat_wr_en_q <= 1'b0;
      regwr_q     <= '0;
      exp_q       <= '0;
      rw_q        <= '0;
      pw_q        <= '0;
    end else begin
      regwr_q <= commit & rob.head_regwr;
      exp_q   <= commit & rob.head_exp;
      for (int s = 0; s < 3; s++) begin
        rw_q[s*AREG_W +: AREG_W] <= commit[s] ? rob.head_rw[s*AREG_W +: AREG_W] : '0;
        pw_q[s*PREG_W +: PREG_W] <= commit[s] ? rob.head_pw[s*PREG_W +: PREG_W] : '0;
      end
      flush_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (exc_commit) begin
            state_q <= StFlush;
            flush_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StFlush: begin
          state_q     <= StRestore;
          rat_wr_en_q <= 1'b1;
        end
        StRestore: begin
          // Power-of-two walk length: the increment wraps back to 0 on exit
          cnt_q <= cnt_q + AREG_W'(1);
          if (cnt_q == AREG_W'(NUM_AREG - 1)) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            rat_wr_en_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign RegWr_x     = regwr_q[0];
  assign RegWr_y     = regwr_q[1];
  assign RegWr_z     = regwr_q[2];
  assign exp_x       = exp_q[0];
  assign exp_y       = exp_q[1];
  assign exp_z       = exp_q[2];
  assign Rw_commit_x = rw_q[0*AREG_W +: AREG_W];
  assign Rw_commit_y = rw_q[1*AREG_W +: AREG_W];
  assign Rw_commit_z = rw_q[2*AREG_W +: AREG_W];
  assign Pw_commit_x = pw_q[0*PREG_W +: PREG_W];
  assign Pw_commit_y = pw_q[1*PREG_W +: PREG_W];
  assign Pw_commit_z = pw_q[2*PREG_W +: PREG_W];
  assign flush       = flush_q;
  assign busy        = busy_q;
  assign rat_wr_en   = rat_wr_en_q;
  assign arat_rd_idx = cnt_q;
  assign rat_wr_idx  = cnt_q;
  assign rat_wr_pw   = arat_rd_pw;

`ifdef COMMIT_PERF_CNT_EN
  logic [31:0] perf_commit_q;
  logic [15:0] perf_exc_q;

  // Retired-instruction and recovery-entry counters; both wrap freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_commit_q <= '0;
      perf_exc_q    <= '0;
    end else begin
      perf_commit_q <= perf_commit_q + {30'd0, pop};
      perf_exc_q    <= perf_exc_q + {15'd0, exc_commit};
    end
  end

  assign perf_commit = perf_commit_q;
  assign perf_exc    = perf_exc_q;
`else
  assign perf_commit = 32'd0;
  assign perf_exc    = 16'd0;
`endif

endmodule

// File: tb/tb_commit_recovery_ctrl.sv
// Self-checking bench for commit_recovery_ctrl: vector table for commit selection,
// scoreboard for the registered commit outputs, hand sequences for recovery and reset.
module tb_commit_recovery_ctrl;

  localparam int unsigned AW = 3;
  localparam int unsigned PW = 5;
`ifdef COMMIT_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  commit_recovery_ctrl_if #(.AREG_W(AW), .PREG_W(PW)) hb ();

  logic          RegWr_x, RegWr_y, RegWr_z, exp_x, exp_y, exp_z;
  logic [AW-1:0] Rw_commit_x, Rw_commit_y, Rw_commit_z;
  logic [PW-1:0] Pw_commit_x, Pw_commit_y, Pw_commit_z;
  logic          flush, rat_wr_en, busy;
  logic [AW-1:0] arat_rd_idx, rat_wr_idx;
  logic [PW-1:0] arat_rd_pw, rat_wr_pw;
  logic [31:0]   perf_commit;
  logic [15:0]   perf_exc;

  logic [PW-1:0] arat [8];
  assign arat_rd_pw = arat[arat_rd_idx];

  commit_recovery_ctrl #(.NUM_AREG(8), .AREG_W(AW), .PREG_W(PW)) dut (
    .clk(clk), .rst(rst), .rob(hb),
    .RegWr_x(RegWr_x), .RegWr_y(RegWr_y), .RegWr_z(RegWr_z),
    .exp_x(exp_x), .exp_y(exp_y), .exp_z(exp_z),
    .Rw_commit_x(Rw_commit_x), .Rw_commit_y(Rw_commit_y), .Rw_commit_z(Rw_commit_z),
    .Pw_commit_x(Pw_commit_x), .Pw_commit_y(Pw_commit_y), .Pw_commit_z(Pw_commit_z),
    .flush(flush), .arat_rd_idx(arat_rd_idx), .arat_rd_pw(arat_rd_pw),
    .rat_wr_en(rat_wr_en), .rat_wr_idx(rat_wr_idx), .rat_wr_pw(rat_wr_pw),
    .busy(busy), .perf_commit(perf_commit), .perf_exc(perf_exc)
  );

  typedef struct packed {
    logic [2:0]  regwr;
    logic [2:0]  exp;
    logic [8:0]  rw;
    logic [14:0] pw;
  } rec_t;

  typedef struct {
    logic [2:0] v, d, e, w;
    logic [1:0] pop;
  } vec_t;

  rec_t sb [$];
  vec_t vecs [10];
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One decision cycle: drive at negedge, check rob_pop, then check registered outputs.
  task automatic cycle(input logic [2:0] v, input logic [2:0] d, input logic [2:0] e,
                       input logic [2:0] w, input logic [8:0] rw, input logic [14:0] pw,
                       input logic [1:0] exp_pop, input logic rst_val);
    rec_t       c;
    rec_t       got;
    logic [2:0] m;
    @(negedge clk);
    rst           = rst_val;
    hb.head_valid = v;
    hb.head_done  = d;
    hb.head_exp   = e;
    hb.head_regwr = w;
    hb.head_rw    = rw;
    hb.head_pw    = pw;
    #1;
    chk("rob_pop", {30'd0, hb.rob_pop}, {30'd0, exp_pop});
    m = (exp_pop == 2'd3) ? 3'b111 : (exp_pop == 2'd2) ? 3'b011 :
        (exp_pop == 2'd1) ? 3'b001 : 3'b000;
    c.regwr = m & w;
    c.exp   = m & e;
    for (int s = 0; s < 3; s++) begin
      c.rw[s*3 +: 3] = m[s] ? rw[s*3 +: 3] : 3'd0;
      c.pw[s*5 +: 5] = m[s] ? pw[s*5 +: 5] : 5'd0;
    end
    sb.push_back(c);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      chk("regwr", {29'd0, RegWr_z, RegWr_y, RegWr_x}, {29'd0, got.regwr});
      chk("exp",   {29'd0, exp_z, exp_y, exp_x},       {29'd0, got.exp});
      chk("rw",    {23'd0, Rw_commit_z, Rw_commit_y, Rw_commit_x}, {23'd0, got.rw});
      chk("pw",    {17'd0, Pw_commit_z, Pw_commit_y, Pw_commit_x}, {17'd0, got.pw});
    end
  endtask

  task automatic chk_ctrl(input string name, input logic f, input logic b, input logic we,
                          input int idx);
    chk({name, "_flush"}, {31'd0, flush}, {31'd0, f});
    chk({name, "_busy"}, {31'd0, busy}, {31'd0, b});
    chk({name, "_wr_en"}, {31'd0, rat_wr_en}, {31'd0, we});
    chk({name, "_wr_idx"}, {29'd0, rat_wr_idx}, 32'(idx));
    chk({name, "_rd_idx"}, {29'd0, arat_rd_idx}, 32'(idx));
    if (we) chk({name, "_wr_pw"}, {27'd0, rat_wr_pw}, {27'd0, arat[idx]});
  endtask

  localparam logic [8:0]  Rw123  = {3'd3, 3'd2, 3'd1};
  localparam logic [14:0] Pw9_11 = {5'd11, 5'd10, 5'd9};

  initial begin
    for (int i = 0; i < 8; i++) arat[i] = PW'($urandom_range(0, 31));
    //          valid   done    exp     regwr   pop
    vecs[0] = '{3'b111, 3'b111, 3'b000, 3'b111, 2'd3};
    vecs[1] = '{3'b111, 3'b101, 3'b000, 3'b111, 2'd1};
    vecs[2] = '{3'b111, 3'b011, 3'b000, 3'b010, 2'd2};
    vecs[3] = '{3'b000, 3'b111, 3'b000, 3'b111, 2'd0};
    vecs[4] = '{3'b110, 3'b111, 3'b000, 3'b111, 2'd0};
    vecs[5] = '{3'b111, 3'b110, 3'b010, 3'b111, 2'd0};
    vecs[6] = '{3'b011, 3'b001, 3'b100, 3'b001, 2'd1};
    vecs[7] = '{3'b111, 3'b111, 3'b000, 3'b000, 2'd3};
    vecs[8] = '{3'b111, 3'b111, 3'b000, 3'b101, 2'd3};
    vecs[9] = '{3'b101, 3'b101, 3'b000, 3'b111, 2'd1};

    // Reset with random heads
    for (int i = 0; i < 2; i++) begin
      cycle(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 9'($urandom),
            15'($urandom), 2'd0, 1'b1);
      chk_ctrl("reset", 1'b0, 1'b0, 1'b0, 0);
      chk("reset_perf_commit", perf_commit, 32'd0);
      chk("reset_perf_exc", {16'd0, perf_exc}, 32'd0);
    end

    // Commit selection table
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].e, vecs[i].w,
            {3'(i + 3), 3'(i + 2), 3'(i + 1)}, {5'(i + 11), 5'(i + 10), 5'(i + 9)},
            vecs[i].pop, 1'b0);
      chk_ctrl("table", 1'b0, 1'b0, 1'b0, 0);
    end

    // Exception on y: commit x,y then flush and an 8-step restore walk
    cycle(3'b111, 3'b111, 3'b010, 3'b111, Rw123, Pw9_11, 2'd2, 1'b0);
    chk_ctrl("exc_flush", 1'b1, 1'b1, 1'b0, 0);
    for (int k = 0; k < 8; k++) begin
      cycle(3'b111, 3'b111, 3'b000, 3'b111, Rw123, Pw9_11, 2'd0, 1'b0);
      chk_ctrl("restore", 1'b0, 1'b1, 1'b1, k);
    end
    cycle(3'b111, 3'b111, 3'b000, 3'b111, Rw123, Pw9_11, 2'd0, 1'b0);
    chk_ctrl("exc_done", 1'b0, 1'b0, 1'b0, 0);
    // Commits resume; same Rw in every slot passes through unchanged
    cycle(3'b111, 3'b111, 3'b000, 3'b111, {3'd5, 3'd5, 3'd5}, Pw9_11, 2'd3, 1'b0);
    chk_ctrl("resume", 1'b0, 1'b0, 1'b0, 0);

    // Two exceptions in the window: only x commits, then reset lands at walk index 4
    cycle(3'b111, 3'b111, 3'b011, 3'b111, Rw123, Pw9_11, 2'd1, 1'b0);
    chk_ctrl("exc2_flush", 1'b1, 1'b1, 1'b0, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(3'b111, 3'b111, 3'b000, 3'b111, Rw123, Pw9_11, 2'd0, 1'b0);
      chk_ctrl("restore2", 1'b0, 1'b1, 1'b1, k);
    end
    cycle(3'b111, 3'b111, 3'b000, 3'b111, Rw123, Pw9_11, 2'd0, 1'b1);
    chk_ctrl("mid_reset", 1'b0, 1'b0, 1'b0, 0);
    chk("mid_reset_perf_commit", perf_commit, 32'd0);

    // Perf counters: 3+2+1 commits, then an exception commit of 2
    cycle(3'b111, 3'b111, 3'b000, 3'b111, Rw123, Pw9_11, 2'd3, 1'b0);
    cycle(3'b011, 3'b011, 3'b000, 3'b011, Rw123, Pw9_11, 2'd2, 1'b0);
    cycle(3'b001, 3'b001, 3'b000, 3'b001, Rw123, Pw9_11, 2'd1, 1'b0);
    chk("perf_commit_6", perf_commit, PerfEn ? 32'd6 : 32'd0);
    chk("perf_exc_0", {16'd0, perf_exc}, 32'd0);
    cycle(3'b111, 3'b111, 3'b010, 3'b111, Rw123, Pw9_11, 2'd2, 1'b0);
    chk("perf_commit_8", perf_commit, PerfEn ? 32'd8 : 32'd0);
    chk("perf_exc_1", {16'd0, perf_exc}, PerfEn ? 32'd1 : 32'd0);
    for (int k = 0; k < 9; k++) begin
      cycle(3'b000, 3'b000, 3'b000, 3'b000, Rw123, Pw9_11, 2'd0, 1'b0);
    end
    chk_ctrl("final_idle", 1'b0, 1'b0, 1'b0, 0);
    chk("perf_commit_hold", perf_commit, PerfEn ? 32'd8 : 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
